// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D cache to block-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  // A write-back wins over a read when the D-cache raises both.
  function automatic mem_op_e d_op_decode(input logic wr);
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational two-way picker for mem_arbiter.
// MEM_ARB_RR_EN selects round-robin ties; otherwise the D-cache wins ties.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_ireq,
  input  logic   i_dreq,
  input  owner_e i_last_owner,
  output logic   o_valid,
  output owner_e o_owner
);

  assign o_valid = i_ireq | i_dreq;

  always_comb begin
    o_owner = OWN_I;
    if (i_ireq && i_dreq) begin
`ifdef MEM_ARB_RR_EN
      o_owner = (i_last_owner == OWN_I) ? OWN_D : OWN_I;
`else
      o_owner = OWN_D;
`endif
    end else if (i_dreq) begin
      o_owner = OWN_D;
    end
  end

`ifndef MEM_ARB_RR_EN
  logic w_unused_last_owner;
  assign w_unused_last_owner = i_last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache reads and D-cache reads/write-backs onto one block-memory port.
// Tie-break policy: MEM_ARB_RR_EN defined -> round-robin, undefined -> D-cache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  owner_e            r_last_owner;
  mem_op_e           r_op;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;

  logic              w_d_req;
  logic              w_pick_valid;
  owner_e            w_pick_owner;
  logic              w_grant;
  logic              w_complete;
  mem_op_e           w_d_op;

  assign w_d_req = d_read | d_write;
  assign w_d_op  = d_op_decode(d_write);

  arb_pick u_pick (
    .i_ireq       (i_read),
    .i_dreq       (w_d_req),
    .i_last_owner (r_last_owner),
    .o_valid      (w_pick_valid),
    .o_owner      (w_pick_owner)
  );

  assign w_grant    = (r_state == IDLE) && w_pick_valid;
  assign w_complete = ((r_state == I_BUSY) || (r_state == D_BUSY)) && mem_ready;

  // mem_ready outside the busy states is ignored by construction.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_next = (w_pick_owner == OWN_D) ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_ready) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request fields are latched at grant so later requester changes cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_owner <= OWN_I;
      r_op         <= OP_READ;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else if (w_grant) begin
      r_last_owner <= w_pick_owner;
      if (w_pick_owner == OWN_D) begin
        r_op        <= w_d_op;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else begin
        r_op        <= OP_READ;
        r_mem_addr  <= i_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_grant) begin
      if (w_pick_owner == OWN_D) begin
        r_mem_read  <= (w_d_op == OP_READ);
        r_mem_write <= (w_d_op == OP_WRITE);
      end else begin
        r_mem_read  <= 1'b1;
        r_mem_write <= 1'b0;
      end
    end else if (w_complete) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end
  end

  // Ready pulses during DONE; a write-back leaves d_rdata untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      if (w_complete) begin
        if (r_state == I_BUSY) begin
          r_i_rdata <= mem_rdata;
          r_i_ready <= 1'b1;
        end else begin
          if (r_op == OP_READ) begin
            r_d_rdata <= mem_rdata;
          end
          r_d_ready <= 1'b1;
        end
      end
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign i_ready   = r_i_ready;
  assign d_rdata   = r_d_rdata;
  assign d_ready   = r_d_ready;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && d_read && d_write) begin
      $warning("mem_arbiter: d_read and d_write both high, write-back takes precedence");
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter with a transaction-level model of requesters and memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: written blocks, otherwise an address-derived pattern.
  logic [DW-1:0] mem_m [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {4'h0, a, 4'h1, ~a, 4'h2, a ^ 28'h5A5A5A5, 4'h3, a + 28'd7};
  endfunction

  int            cyc = 0;
  int            req_mode = 0;     // 0 directed, 1 random, 2 continuous
  bit            stray_en = 0;
  int            force_delay = -1;
  bit            i_act = 0, d_act = 0, d_rd_m = 0, d_wr_m = 0;
  logic [AW-1:0] ia_m = '0, da_m = '0;
  logic [DW-1:0] dw_m = '0;

  int            phase = 0;        // 0 free, 1 memory busy, 2 awaiting ready
  int            free_from = 0;
  bit            last_d = 0;
  bit            own_d = 0, op_wr = 0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wdata = '0, t_rdata = '0;
  int            wait_cnt = 0, hold_cnt = 0, exp_ready_cyc = 0;
  logic [DW-1:0] m_i_rdata = '0, m_d_rdata = '0;
  int            strobe_seen = 0;
  bit            obs_own [$];

  task automatic cycle();
    bit strobe, exp_start, ip, dp, i_done_now, d_done_now;
    @(negedge clk);
    cyc++;
    i_done_now = 0;
    d_done_now = 0;
    strobe = mem_read | mem_write;
    if (strobe) strobe_seen++;
    if (!rst) begin
      check("rst_outputs", DW'({mem_read, mem_write, i_ready, d_ready}), '0);
      check("rst_i_rdata", i_rdata, '0);
      check("rst_d_rdata", d_rdata, '0);
      mem_ready = 1'b0;
    end else begin
      if (phase == 2 && cyc == exp_ready_cyc) begin
        check("ready_owner", DW'({i_ready, d_ready}), DW'(own_d ? 2'b01 : 2'b10));
        check("strobe_drop", DW'(strobe), '0);
        if (op_wr) mem_m[t_addr] = t_wdata;
        else if (own_d) m_d_rdata = t_rdata;
        else m_i_rdata = t_rdata;
        obs_own.push_back(d_ready);
        if (own_d) begin d_act = 0; d_done_now = 1; end
        else begin i_act = 0; i_done_now = 1; end
        phase = 0;
        free_from = cyc + 2;
      end else begin
        check("no_ready", DW'({i_ready, d_ready}), '0);
        if (phase == 1) begin
          check("strobe_hold", DW'({mem_read, mem_write, mem_addr}), DW'({~op_wr, op_wr, t_addr}));
          if (op_wr) check("wdata_hold", mem_wdata, t_wdata);
        end else if (phase == 0) begin
          ip = i_read;
          dp = d_read | d_write;
          exp_start = (cyc >= free_from) && (ip || dp);
          check("grant_timing", DW'(strobe), DW'(exp_start));
          if (exp_start) begin
            if (ip && dp) begin
`ifdef MEM_ARB_RR_EN
              own_d = !last_d;
`else
              own_d = 1'b1;
`endif
            end else begin
              own_d = dp;
            end
            last_d  = own_d;
            op_wr   = own_d && d_write;
            t_addr  = own_d ? d_addr : i_addr;
            t_wdata = d_wdata;
            t_rdata = mem_val(t_addr);
            check("grant_op", DW'({mem_read, mem_write}), DW'({~op_wr, op_wr}));
            check("grant_addr", DW'(mem_addr), DW'(t_addr));
            if (op_wr) check("grant_wdata", mem_wdata, t_wdata);
            wait_cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
            phase = 1;
          end
        end
      end
      check("i_rdata_hold", i_rdata, m_i_rdata);
      check("d_rdata_hold", d_rdata, m_d_rdata);

      // Memory model; mem_rdata is garbage except alongside a real completion.
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (phase == 1) begin
        if (wait_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = t_rdata;
          phase = 2;
          exp_ready_cyc = cyc + 1;
          hold_cnt = int'($urandom_range(0, 1));
        end else begin
          wait_cnt--;
        end
      end else if (hold_cnt > 0) begin
        mem_ready = 1'b1;
        hold_cnt--;
      end else if (stray_en && phase == 0 && !strobe && $urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
      end

      if (req_mode != 0) begin
        if (!i_act && !i_done_now && (req_mode == 2 || $urandom_range(0, 3) == 0)) begin
          i_act = 1;
          ia_m  = AW'($urandom_range(0, 15));
        end
        if (!d_act && !d_done_now && (req_mode == 2 || $urandom_range(0, 3) == 0)) begin
          d_act  = 1;
          d_wr_m = 1'($urandom_range(0, 1));
          d_rd_m = !d_wr_m;
          da_m   = AW'($urandom_range(0, 15));
          dw_m   = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      i_read  = i_act;
      i_addr  = i_act ? ia_m : AW'($urandom);
      d_read  = d_act && d_rd_m;
      d_write = d_act && d_wr_m;
      d_addr  = d_act ? da_m : AW'($urandom);
      d_wdata = d_act ? dw_m : {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((i_act || d_act || phase != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", DW'(i_act || d_act || phase != 0), '0);
    cycle();
    cycle();
  endtask

  task automatic apply_reset_mid();
    #2;
    rst = 1'b0;
    #1;
    check("async_strobe_drop", DW'({mem_read, mem_write}), '0);
    check("async_ready", DW'({i_ready, d_ready}), '0);
    mem_ready = 1'b0;
    cycle();
    cycle();
    phase = 0;
    hold_cnt = 0;
    last_d = 0;
    m_i_rdata = '0;
    m_d_rdata = '0;
    rst = 1'b1;
    free_from = cyc + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit exp_first;
    repeat (3) cycle();
    rst = 1'b1;
    free_from = cyc + 1;

    // Single I read, 4-cycle memory latency.
    mem_m[28'h0000010] = 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF;
    force_delay = 3;
    strobe_seen = 0;
    i_act = 1;
    ia_m = 28'h0000010;
    drain(50);
    check("t1_strobe_cycles", DW'(strobe_seen), DW'(4));
    check("t1_i_rdata", i_rdata, 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF);

    // D write-back.
    force_delay = 1;
    d_act = 1; d_wr_m = 1; d_rd_m = 0;
    da_m = 28'h0000020;
    dw_m = 128'h11111111_11111111_11111111_11111111;
    drain(50);
    check("t2_d_rdata_kept", d_rdata, '0);

    // Simultaneous I and D reads.
    force_delay = 0;
    obs_own.delete();
    i_act = 1; ia_m = 28'h0000003;
    d_act = 1; d_rd_m = 1; d_wr_m = 0; da_m = 28'h0000004;
    drain(50);
`ifdef MEM_ARB_RR_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    check("t3_count", DW'(obs_own.size()), DW'(2));
    if (obs_own.size() == 2) begin
      check("t3_first_owner", DW'(obs_own[0]), DW'(exp_first));
      check("t3_second_owner", DW'(obs_own[1]), DW'(!exp_first));
    end

    // Continuous traffic on both ports.
    force_delay = -1;
    obs_own.delete();
    req_mode = 2;
    n = 0;
    while (obs_own.size() < 8 && n < 400) begin
      cycle();
      n++;
    end
    req_mode = 0;
    check("t4_count", DW'(obs_own.size() >= 8), DW'(1));
    for (int k = 0; k < 8 && k < obs_own.size(); k++) begin
`ifdef MEM_ARB_RR_EN
      check("t4_alternate", DW'(obs_own[k]), DW'(k % 2));
`else
      check("t4_d_priority", DW'(obs_own[k]), DW'(1));
`endif
    end
    drain(200);

    // Reset while a D read is in flight.
    force_delay = 8;
    d_act = 1; d_rd_m = 1; d_wr_m = 0; da_m = 28'h0000005;
    n = 0;
    while (phase != 1 && n < 20) begin
      cycle();
      n++;
    end
    check("t5_reached_busy", DW'(phase), DW'(1));
    cycle();
    cycle();
    force_delay = 1;
    apply_reset_mid();
    drain(50);
    check("t5_d_rdata_after", d_rdata, mem_val(28'h0000005));

    // d_read and d_write together: the write must win.
    d_act = 1; d_rd_m = 1; d_wr_m = 1; da_m = 28'h0000030;
    dw_m = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    drain(50);
    d_act = 1; d_rd_m = 1; d_wr_m = 0; da_m = 28'h0000030;
    drain(50);
    check("t6_readback", d_rdata, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);

    // Random traffic with random latency and stray mem_ready.
    force_delay = -1;
    stray_en = 1;
    req_mode = 1;
    repeat (1500) cycle();
    req_mode = 0;
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single 128-bit block-memory port between the instruction cache (read-only) and the data cache (read and write-back). Sits between the two caches and the slow memory model, serialises their miss/write-back transactions, and returns read data and a one-cycle ready to the owning requester. Processor-side test monitors on the data path are unaffected; only cache-to-memory traffic passes through this block.

## Interface
- ADDR_W, 28, block address width (word address bits [29:2]).
- DATA_W, 128, block data width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; state and outputs clear while low.
- i_read  in  1  I-cache read request; held until i_ready.
- i_addr  in  ADDR_W  I-cache block address.
- i_rdata  out  DATA_W  read data to I-cache, valid while i_ready.
- i_ready  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache read request; held until d_ready.
- d_write  in  1  D-cache write-back request; held until d_ready.
- d_addr  in  ADDR_W  D-cache block address.
- d_wdata  in  DATA_W  D-cache write data.
- d_rdata  out  DATA_W  read data to D-cache, valid while d_ready.
- d_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory block address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, one or more cycles high.

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY, DONE. Reset -> IDLE.
- IDLE: if any request pending, pick owner (see Configuration), latch addr/wdata/op into registers, go to I_BUSY or D_BUSY. No request -> stay.
- D op decode: d_write has precedence over d_read if both high (illegal; simulation assertion fires).
- I_BUSY/D_BUSY: mem_read/mem_write held high with latched addr/wdata; requester input changes ignored. On mem_ready: capture mem_rdata into owner's rdata register, drop strobes, go to DONE.
- DONE: owner's ready high for exactly one cycle; rdata stable; then IDLE. DONE blocks re-grant of a request the owner drops at the DONE edge.
- Non-owner requests wait; never dropped, never reordered within a port.
- mem_ready in IDLE or DONE: ignored.
- Write completion: d_ready pulses; d_rdata unchanged.

## Timing
- Reset values: all outputs 0, i_rdata/d_rdata 0, state IDLE.
- Strobes registered: request seen at edge N -> mem_read/mem_write high from N+1.
- mem_ready sampled high at edge M -> strobes low and ready high from M+1, for one cycle; next grant no earlier than M+2 (strobes high at M+3 at earliest).
- Minimum transaction: 3 cycles request-to-ready with single-cycle mem_ready response; back-to-back grants separated by one idle cycle.
- Reset asserted mid-transaction: strobes drop immediately (asynchronous), transaction abandoned, no ready issued; memory model must tolerate.
- Simultaneous i_read and d_read/d_write in IDLE: arbitration rule decides; loser granted in the next IDLE.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; one-bit last-owner register (reset: I), on tie the port not granted last wins.
- Undefined: fixed priority, D-cache always wins ties (I can starve under continuous D traffic; acceptable because D misses stall the pipeline).

## Structure
- Package mem_arb_pkg: state enum (IDLE, I_BUSY, D_BUSY, DONE), owner encoding (OWN_I=0, OWN_D=1), default ADDR_W/DATA_W constants.
- Sub-module arb_pick: combinational 2-way picker (inputs two requests plus last-owner, output grant-valid and owner), holds the MEM_ARB_RR_EN choice; FSM and datapath registers stay in mem_arbiter.

## Test plan
- Single I read addr 0x0000010, memory returns 0x...DEADBEEF after 4 cycles -> mem_read high 4 cycles with mem_addr 0x0000010, i_ready one cycle with i_rdata 0x...DEADBEEF, d_ready stays 0.
- D write-back addr 0x0000020, wdata 0x1111...1111 -> mem_write high, mem_wdata matches, d_ready pulse, d_rdata unchanged.
- i_read and d_read same cycle, fixed mode -> D served first, I granted in the IDLE after DONE; with MEM_ARB_RR_EN and last-owner D -> I first.
- Continuous alternating requests with MEM_ARB_RR_EN -> grants strictly alternate I,D,I,D over 8 transactions.
- Reset low 2 cycles during D_BUSY -> strobes 0 asynchronously, no ready, next request after reset completes normally.
- d_read and d_write both high -> write performed, assertion reported.
